execute_stage: RTL

Execute stage of the 5-bit-PC RISC-V pipeline. Sits directly downstream of `fetch_decode`: latches its decoded operands and control into an ID/EX register, then resolves operand forwarding, ALU operation and branch/jump outcome. It returns `should_jump`/`jump_pc` to fetch, squashes the one wrong-path instruction, and drives an EX/MEM register toward the memory stage.

---
 rtl/execute_stage.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// Execute stage of the 5-bit-PC RISC-V pipeline: ID/EX register, operand
// forwarding, ALU, branch/jump resolution and the EX/MEM register.
module execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  input  logic [4:0]  write_reg,
  input  logic        reg_wrenable,
  input  logic        mem_wrenable,
  input  logic        mem_to_reg,
  input  logic        alu_src,
  input  logic [4:0]  alu_op,
  input  logic [3:0]  jump_type,
  input  logic [4:0]  pc,
  input  logic [31:0] mem_result,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_data,
  input  logic        wb_wrenable,
  output logic        should_jump,
  output logic [4:0]  jump_pc,
  output logic [31:0] alu_result,
  output logic [31:0] store_data,
  output logic [4:0]  out_write_reg,
  output logic        out_reg_wrenable,
  output logic        out_mem_wrenable,
  output logic        out_mem_to_reg
);

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASS_B = 5'd10
  } alu_op_e;

  typedef enum logic [3:0] {
    JT_NONE = 4'd0,
    JT_BEQ  = 4'd1,
    JT_BNE  = 4'd2,
    JT_BLT  = 4'd3,
    JT_BGE  = 4'd4,
    JT_BLTU = 4'd5,
    JT_BGEU = 4'd6,
    JT_JAL  = 4'd7,
    JT_JALR = 4'd8
  } jump_type_e;

  // ID/EX register contents
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_write_reg, ex_alu_op, ex_pc;
  logic        ex_reg_we, ex_mem_we, ex_mem_to_reg, ex_alu_src;
  logic [3:0]  ex_jump_type;

  // Resolved operands and results in EX
  logic [31:0] fwd_a, fwd_b, op_b, alu_val;
  logic        taken, is_link;
  logic [4:0]  target;

  // ID/EX register; a taken jump in EX squashes the wrong-path instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_write_reg  <= '0;
      ex_alu_op     <= '0;
      ex_pc         <= '0;
      ex_reg_we     <= 1'b0;
      ex_mem_we     <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_jump_type  <= '0;
    end else if (should_jump) begin
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_write_reg  <= '0;
      ex_alu_op     <= '0;
      ex_pc         <= '0;
      ex_reg_we     <= 1'b0;
      ex_mem_we     <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_jump_type  <= '0;
    end else begin
      ex_rd1        <= read_data1;
      ex_rd2        <= read_data2;
      ex_imm        <= imm;
      ex_rs1        <= rs1;
      ex_rs2        <= rs2;
      ex_write_reg  <= write_reg;
      ex_alu_op     <= alu_op;
      ex_pc         <= pc;
      ex_reg_we     <= reg_wrenable;
      ex_mem_we     <= mem_wrenable;
      ex_mem_to_reg <= mem_to_reg;
      ex_alu_src    <= alu_src;
      ex_jump_type  <= jump_type;
    end
  end

  // Forwarding: x0 never forwarded; EX/MEM result beats writeback
  always_comb begin
    fwd_a = ex_rd1;
    if (ex_rs1 != '0) begin
      if (out_reg_wrenable && out_write_reg == ex_rs1) fwd_a = mem_result;
      else if (wb_wrenable && wb_write_reg == ex_rs1)  fwd_a = wb_data;
    end
    fwd_b = ex_rd2;
    if (ex_rs2 != '0) begin
      if (out_reg_wrenable && out_write_reg == ex_rs2) fwd_b = mem_result;
      else if (wb_wrenable && wb_write_reg == ex_rs2)  fwd_b = wb_data;
    end
    op_b = ex_alu_src ? ex_imm : fwd_b;
  end

  // ALU; jumps replace the ALU value with the link byte address
  always_comb begin
    alu_val = '0;
    case (ex_alu_op)
      ALU_ADD:    alu_val = fwd_a + op_b;
      ALU_SUB:    alu_val = fwd_a - op_b;
      ALU_SLL:    alu_val = fwd_a << op_b[4:0];
      ALU_SLT:    alu_val = {31'b0, $signed(fwd_a) < $signed(op_b)};
      ALU_SLTU:   alu_val = {31'b0, fwd_a < op_b};
      ALU_XOR:    alu_val = fwd_a ^ op_b;
      ALU_SRL:    alu_val = fwd_a >> op_b[4:0];
      ALU_SRA:    alu_val = $signed(fwd_a) >>> op_b[4:0];
      ALU_OR:     alu_val = fwd_a | op_b;
      ALU_AND:    alu_val = fwd_a & op_b;
      ALU_PASS_B: alu_val = op_b;
      default:    alu_val = '0;
    endcase
    is_link = (ex_jump_type == JT_JAL) || (ex_jump_type == JT_JALR);
    if (is_link) alu_val = {25'b0, ex_pc + 5'd1, 2'b00};
  end

  // Branch/jump condition and word-PC target (mod 32)
  always_comb begin
    taken = 1'b0;
    case (ex_jump_type)
      JT_BEQ:  taken = (fwd_a == fwd_b);
      JT_BNE:  taken = (fwd_a != fwd_b);
      JT_BLT:  taken = ($signed(fwd_a) < $signed(fwd_b));
      JT_BGE:  taken = ($signed(fwd_a) >= $signed(fwd_b));
      JT_BLTU: taken = (fwd_a < fwd_b);
      JT_BGEU: taken = (fwd_a >= fwd_b);
      JT_JAL:  taken = 1'b1;
      JT_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    if (ex_jump_type == JT_JALR) target = 5'((fwd_a + ex_imm) >> 2);
    else                         target = ex_pc + ex_imm[6:2];
    should_jump = taken;
    jump_pc     = taken ? target : '0;
  end

  // EX/MEM register; bubbles flow through unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result       <= '0;
      store_data       <= '0;
      out_write_reg    <= '0;
      out_reg_wrenable <= 1'b0;
      out_mem_wrenable <= 1'b0;
      out_mem_to_reg   <= 1'b0;
    end else begin
      alu_result       <= alu_val;
      store_data       <= fwd_b;
      out_write_reg    <= ex_write_reg;
      out_reg_wrenable <= ex_reg_we;
      out_mem_wrenable <= ex_mem_we;
      out_mem_to_reg   <= ex_mem_to_reg;
    end
  end

endmodule
